// File: rtl/debounce_fsm.sv
// Switch debouncer: synchronises a raw bouncy input and qualifies each
// transition with a Moore FSM and down-counter before moving `level`.
module debounce_fsm #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic sw,
    output logic level,
    output logic busy
);

    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ZERO,
        WAIT1,
        ONE,
        WAIT0
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s;
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   busy_q, busy_d;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], sw};
        s       = sync_q[SYNC_STAGES-1];
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ZERO: begin
                if (s) begin
                    state_d = WAIT1;
                    cnt_d   = CNT_TOP;
                end
            end
            WAIT1: begin
                if (!s)
                    state_d = ZERO;
                else if (cnt_q == '0)
                    state_d = ONE;
                else
                    cnt_d = cnt_q - CNT_W'(1);
            end
            ONE: begin
                if (!s) begin
                    state_d = WAIT0;
                    cnt_d   = CNT_TOP;
                end
            end
            WAIT0: begin
                if (s)
                    state_d = ONE;
                else if (cnt_q == '0)
                    state_d = ZERO;
                else
                    cnt_d = cnt_q - CNT_W'(1);
            end
            default: state_d = ZERO;
        endcase
        // Outputs decoded from the next state so they register with it.
        level_d = (state_d == ONE) || (state_d == WAIT0);
        busy_d  = (state_d == WAIT1) || (state_d == WAIT0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            state_q <= ZERO;
            cnt_q   <= '0;
            level_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            busy_q  <= busy_d;
        end
    end

    assign level = level_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_debounce_fsm.sv
// Scoreboard bench for debounce_fsm: default build plus a short
// SYNC_STAGES=3 / STABLE_CYCLES=2 build, checked against a run-length model.
module tb_debounce_fsm;

    localparam int SA = 2, TA = 8;
    localparam int SB = 3, TB = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sw = 1'b0;
    logic level_a, busy_a, level_b, busy_b;

    always #5 clk = ~clk;

    debounce_fsm #(.SYNC_STAGES(SA), .STABLE_CYCLES(TA)) dut_a (
        .clk(clk), .reset(reset), .sw(sw),
        .level(level_a), .busy(busy_a)
    );

    debounce_fsm #(.SYNC_STAGES(SB), .STABLE_CYCLES(TB)) dut_b (
        .clk(clk), .reset(reset), .sw(sw),
        .level(level_b), .busy(busy_b)
    );

    typedef struct {
        bit la;
        bit ba;
        bit lb;
        bit bb;
    } exp_t;

    exp_t exp_q[$];
    bit   dly_a[$];
    bit   dly_b[$];
    int   lvl_a, run_a, lvl_b, run_b;
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    endtask

    // Model: s must differ from the current level on STABLE+1 consecutive
    // edges; busy is high whenever a run is in progress.
    function automatic void upd(inout int lvl, inout int run,
                                input bit s, input int stable);
        if (int'(s) != lvl) begin
            run++;
            if (run == stable + 1) begin
                lvl = int'(s);
                run = 0;
            end
        end else begin
            run = 0;
        end
    endfunction

    task automatic model_reset();
        lvl_a = 0; run_a = 0; lvl_b = 0; run_b = 0;
        dly_a.delete();
        dly_b.delete();
        for (int i = 0; i < SA; i++) dly_a.push_back(1'b0);
        for (int i = 0; i < SB; i++) dly_b.push_back(1'b0);
    endtask

    task automatic tick(input bit v);
        exp_t e;
        bit sa, sb;
        sw = v;
        @(posedge clk);
        #1;
        sa = dly_a.pop_front();
        dly_a.push_back(v);
        sb = dly_b.pop_front();
        dly_b.push_back(v);
        upd(lvl_a, run_a, sa, TA);
        upd(lvl_b, run_b, sb, TB);
        e.la = (lvl_a != 0);
        e.ba = (run_a != 0);
        e.lb = (lvl_b != 0);
        e.bb = (run_b != 0);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        #1 reset = 1'b1;
        #1;
        chk("async_rst_level", int'(level_a), 0);
        chk("async_rst_busy", int'(busy_a), 0);
        #2 reset = 1'b0;
        model_reset();
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("level_a", int'(level_a), int'(e.la));
            chk("busy_a", int'(busy_a), int'(e.ba));
            chk("level_b", int'(level_b), int'(e.lb));
            chk("busy_b", int'(busy_b), int'(e.bb));
        end
    end

    initial begin
        int rise_a, rise_b, fall_a, busy_first, busy_last, rises, t0;
        bit prev;
        model_reset();
        #2;
        chk("reset_level", int'(level_a), 0);
        chk("reset_busy", int'(busy_a), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Clean press: count edges from sw going high.
        rise_a = 0; rise_b = 0; busy_first = 0; busy_last = 0;
        rises = 0; prev = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick(1'b1);
            if (level_a && !prev) rises++;
            if (level_a && rise_a == 0) rise_a = i;
            if (level_b && rise_b == 0) rise_b = i;
            if (busy_a && busy_first == 0) busy_first = i;
            if (busy_a) busy_last = i;
            prev = level_a;
        end
        chk("press_rise_edge", rise_a, SA + 1 + TA);
        chk("press_busy_first", busy_first, SA + 1);
        chk("press_busy_last", busy_last, SA + TA);
        chk("press_one_tick", rises, 1);
        chk("sweep_rise_edge", rise_b, SB + 1 + TB);

        // Release with a one-cycle glitch at edge 6 of the wait.
        fall_a = 0;
        for (int i = 1; i <= 30; i++) begin
            tick(i == 6 ? 1'b1 : 1'b0);
            if (!level_a && fall_a == 0) fall_a = i;
        end
        chk("release_glitch_fall", fall_a - 6, SA + 1 + TA);

        // Bounce every two cycles, then settle low.
        rises = 0;
        for (int i = 0; i < 20; i++) begin
            tick((i % 4) < 2);
            if (level_a) rises++;
        end
        for (int i = 0; i < 15; i++) begin
            tick(1'b0);
            if (level_a) rises++;
        end
        chk("bounce_level_low", rises, 0);

        // Three bounces, then settle high.
        rise_a = 0;
        t0 = 0;
        for (int i = 1; i <= 12; i++) begin
            tick((i % 4) != 0);
            if (level_a && rise_a == 0) rise_a = i;
        end
        t0 = 13;
        for (int i = 13; i <= 27; i++) begin
            tick(1'b1);
            if (level_a && rise_a == 0) rise_a = i;
        end
        chk("settle_rise_edges", rise_a - t0 + 1, SA + 1 + TA);

        // Async reset while in WAIT0.
        for (int i = 0; i < 4; i++) tick(1'b0);
        chk("wait0_level", int'(level_a), 1);
        chk("wait0_busy", int'(busy_a), 1);
        pulse_reset();
        rises = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1'b0);
            if (level_a || busy_a) rises++;
        end
        chk("post_reset_zero", rises, 0);

        // Short build: two-sample high pulse must be rejected.
        rises = 0;
        tick(1'b1);
        tick(1'b1);
        for (int i = 0; i < 10; i++) begin
            tick(1'b0);
            if (level_b) rises++;
        end
        chk("sweep_pulse_reject", rises, 0);

        // Random hold lengths around the qualification window.
        for (int seg = 0; seg < 80; seg++) begin
            bit v;
            int len;
            v = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 14));
            for (int j = 0; j < len; j++) tick(v);
        end

        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/debounce_fsm.md
Name: debounce_fsm

Overview:
- Upstream conditioning stage for the edge detector.
- Takes a raw, asynchronous, bouncy switch input and synchronises it into the clock domain.
- Filters the synchronised input with a Moore FSM plus a down-counter.
- Drives a clean, glitch-free `level` that feeds the edge detector's `level` input directly, so the edge detector emits exactly one tick per real press/release.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on `sw`; legal range ≥2.
- STABLE_CYCLES, 8, number of clock edges the synchronised input must stay at the new value, after the first sample, before `level` changes; legal range ≥2.
- CNT_W, $clog2(STABLE_CYCLES), down-counter width; derived, never overridden.

Ports:
- clk    input   1  system clock, rising-edge active.
- reset  input   1  asynchronous, active-high reset.
- sw     input   1  raw switch/button input; asynchronous to clk and may bounce.
- level  output  1  debounced level; registered Moore output.
- busy   output  1  high while a candidate transition is being qualified (WAIT1/WAIT0 states); registered.

Behaviour:
- Reset (asynchronous, takes effect immediately, independent of clk):
  - All synchroniser flops = 0.
  - state = ZERO, counter = 0.
  - level = 0, busy = 0.
- Synchroniser:
  - A chain of SYNC_STAGES flops; `s` is the last flop.
  - The FSM and counter use only `s`, never `sw`.
- State ZERO (level=0, busy=0):
  - s=1 → WAIT1, counter loaded with STABLE_CYCLES-1.
  - Otherwise stay in ZERO.
- State WAIT1 (level=0, busy=1):
  - s=0 → ZERO (bounce rejected, counter value irrelevant).
  - Else counter==0 → ONE.
  - Else decrement the counter.
- State ONE (level=1, busy=0):
  - s=0 → WAIT0, counter loaded with STABLE_CYCLES-1.
- State WAIT0 (level=1, busy=1):
  - s=1 → ONE.
  - Else counter==0 → ZERO.
  - Else decrement the counter.
- Outputs:
  - `level` and `busy` are decoded from registered state only. No combinational path from `sw`.
  - `level` never toggles twice within STABLE_CYCLES+1 cycles.
- Latency:
  - `sw` stable high from before edge 1 → `s`=1 after edge SYNC_STAGES → WAIT1 after edge SYNC_STAGES+1 → level=1 after edge SYNC_STAGES+1+STABLE_CYCLES.
  - Defaults: level rises after edge 11; busy is high after edges 3..10.
  - Falling edge is symmetric.
- Qualification rule: `s` must be sampled at the new value on STABLE_CYCLES+1 consecutive edges. Any single sample at the old value during WAIT returns the FSM to the stable state of the old value, and the count restarts from the top on the next candidate.
- Counter:
  - Unsigned, CNT_W bits.
  - Never wraps: decrements only in WAIT states while nonzero.
  - Holds its value in ZERO/ONE.
- Reset mid-WAIT: the FSM returns immediately to ZERO with level=0, even if it was in WAIT0 or ONE.
- An `sw` pulse shorter than one clock period may or may not be captured by the synchroniser. If captured, it is rejected because it cannot survive qualification.

Test Plan:
- Reset then clean press: assert reset, release, drive sw=1 before edge 1 and hold → busy=1 after edges 3..10, level=1 after edge 11, busy=0 from edge 11. Chain into the edge detector and check exactly one ticc.
- Bounce rejection: sw toggles 1/0 every 2 cycles for 20 cycles, then settles to 0 → level stays 0 throughout; busy pulses; final state ZERO.
- Bounce then settle high: 3 bounces (sw high for 3 cycles, low for 1), then high for 15 cycles → level rises exactly SYNC_STAGES+1+STABLE_CYCLES=11 edges after the final 0→1 of sw, with no earlier rise.
- Release: from level=1, drive sw=0 and hold → level=0 after edge 11; a 1-cycle sw=1 glitch at edge 6 of the wait restarts qualification, so level falls 11 edges after the glitch ends.
- Async reset mid-qualification: in WAIT0 (level=1, busy=1), pulse reset for 3 ns between clock edges → level=0 and busy=0 immediately, before the next edge; with sw=0 held, the design remains in ZERO.
- Parameter sweep: STABLE_CYCLES=2, SYNC_STAGES=3; hold sw=1 → level=1 after edge 6. A 2-cycle high pulse on `s` is rejected.
